// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode enum, flag bit positions and
// the stage-1 control payload.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_SAR = 4'd8,
        OP_CMP = 4'd9
    } alu_op_t;

    // Bit positions inside the 4-bit {C, V, Z, N} flag vector.
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    // Width-independent part of the stage-1 payload. Operands and tag are
    // parameterised by the instantiating module and sit beside this struct.
    typedef struct packed {
        logic    valid;
        alu_op_t op;
    } s1_ctrl_t;

endpackage

// File: rtl/alu_exec.sv
// Combinational ALU core: result, {C,V,Z,N} flags and illegal-opcode error.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err
);

    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0]  amt;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [WIDTH:0]   sar_ext;
    logic [WIDTH-1:0] res_calc;
    logic             c_bit;
    logic             v_bit;

    assign amt  = b[SH_W-1:0];
    assign sum  = {1'b0, a} + {1'b0, b};
    // MSB of the extended difference is the unsigned borrow.
    assign diff = {1'b0, a} - {1'b0, b};
    // One guard bit on the outgoing side catches the last bit shifted out;
    // it stays 0 for a zero shift amount.
    assign shl_ext = {1'b0, a} << amt;
    assign shr_ext = {a, 1'b0} >> amt;
    assign sar_ext = $signed({a, 1'b0}) >>> amt;

    // Per-opcode result and C/V; Z and N are derived uniformly afterwards.
    always_comb begin
        res_calc = '0;
        c_bit    = 1'b0;
        v_bit    = 1'b0;
        err      = 1'b0;
        case (op)
            OP_ADD: begin
                res_calc = sum[WIDTH-1:0];
                c_bit    = sum[WIDTH];
                v_bit    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                res_calc = diff[WIDTH-1:0];
                c_bit    = diff[WIDTH];
                v_bit    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res_calc = a & b;
            OP_OR:  res_calc = a | b;
            OP_XOR: res_calc = a ^ b;
            OP_NOT: res_calc = ~a;
            OP_SHL: begin
                res_calc = shl_ext[WIDTH-1:0];
                c_bit    = shl_ext[WIDTH];
            end
            OP_SHR: begin
                res_calc = shr_ext[WIDTH:1];
                c_bit    = shr_ext[0];
            end
            OP_SAR: begin
                res_calc = sar_ext[WIDTH:1];
                c_bit    = sar_ext[0];
            end
            default: err = 1'b1;
        endcase

        // CMP keeps the flags of the difference (so Z means a==b) but
        // reports a zero result; illegal codes report nothing but err.
        result = (err || op == OP_CMP) ? '0 : res_calc;
        flags  = '0;
        if (!err) begin
            flags[FLAG_C] = c_bit;
            flags[FLAG_V] = v_bit;
            flags[FLAG_Z] = (res_calc == '0);
            flags[FLAG_N] = res_calc[WIDTH-1];
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline with valid/ready on both sides. Stage 1 holds the
// accepted operation, stage 2 holds the computed result presented at out_*.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
);

    s1_ctrl_t         s1_ctrl_q, s1_ctrl_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic [3:0]       s2_flags_q, s2_flags_d;
    logic             s2_err_q, s2_err_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic             s1_adv;
    logic [WIDTH-1:0] exec_result;
    logic [3:0]       exec_flags;
    logic             exec_err;

    // Stage 1 may move on when stage 2 is empty or being drained this edge;
    // in_ready is purely combinational from out_ready and the valid flops.
    assign s1_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_ctrl_q.valid || s1_adv;

    alu_exec #(
        .WIDTH (WIDTH)
    ) u_exec (
        .op     (s1_ctrl_q.op),
        .a      (s1_a_q),
        .b      (s1_b_q),
        .result (exec_result),
        .flags  (exec_flags),
        .err    (exec_err)
    );

    // Next-state for both stages; payloads only load with a valid operation.
    always_comb begin
        s1_ctrl_d   = s1_ctrl_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_tag_d    = s1_tag_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
        s2_err_d    = s2_err_q;
        s2_tag_d    = s2_tag_q;

        if (in_ready) begin
            s1_ctrl_d.valid = in_valid;
            if (in_valid) begin
                s1_ctrl_d.op = alu_op_t'(in_op);
                s1_a_d       = in_a;
                s1_b_d       = in_b;
                s1_tag_d     = in_tag;
            end
        end

        if (s1_adv) begin
            s2_valid_d = s1_ctrl_q.valid;
            if (s1_ctrl_q.valid) begin
                s2_result_d = exec_result;
                s2_flags_d  = exec_flags;
                s2_err_d    = exec_err;
                s2_tag_d    = s1_tag_q;
            end
        end
    end

    // Pipeline registers; reset drops every in-flight operation at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ctrl_q   <= '{valid: 1'b0, op: OP_ADD};
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
            s2_err_q    <= 1'b0;
            s2_tag_q    <= '0;
        end else begin
            s1_ctrl_q   <= s1_ctrl_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
            s2_err_q    <= s2_err_d;
            s2_tag_q    <= s2_tag_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_flags  = s2_flags_q;
    assign out_err    = s2_err_q;
    assign out_tag    = s2_tag_q;

endmodule
